frame_averager_mc: RTL
======================

FRAME_AVERAGER_MC -- requirements
Module: frame_averager_mc

Interface
REQ-001 SHALL have parameter CHANNELS, default 2: number of independent lanes packed in data_in/data_out.
REQ-002 SHALL have parameter DATA_W, default 32: signed sample width per lane.
REQ-003 SHALL have parameter MAX_PTS, default 1024: maximum points per cycle, which sets the accumulator RAM depth.
REQ-004 SHALL have parameter MAX_LOG2_FR, default 8: maximum log2 of the integration frame count.
REQ-005 SHALL have port clk, input, 1: the only clock.
REQ-006 SHALL have port reset_n, input, 1: synchronous, active-low reset.
REQ-007 SHALL have port enable, input, 1: sample-acceptance gate.
REQ-008 SHALL have port ptos_x_ciclo, input, 16: points per frame (N).
REQ-009 SHALL have port log2_frames, input, 4: M = 2^log2_frames.
REQ-010 SHALL have port mode, input, 1: 0 = block average, 1 = exponential average (EMA).
REQ-011 SHALL have port data_in, input, CHANNELS*DATA_W: lane k at bits [k*DATA_W +: DATA_W].
REQ-012 SHALL have port data_in_valid, input, 1: qualifies data_in (streaming, no backpressure).
REQ-013 SHALL have port data_out, output, CHANNELS*DATA_W: averaged samples, same packing as data_in.
REQ-014 SHALL have port data_out_valid, output, 1: qualifies data_out.
REQ-015 SHALL have port ready, output, 1: configuration valid and block out of reset.
REQ-016 SHALL have port cfg_error, output, 1: latched configuration is invalid.
REQ-017 SHALL have port frame_done, output, 1: one-cycle pulse when the last point of an output frame is emitted.
REQ-018 SHALL have port frame_count, output, 16: number of frames accumulated in the current block.

Function
REQ-019 ptos_x_ciclo, log2_frames and mode SHALL be registered on every clk while reset_n=0 and held constant otherwise.
REQ-020 cfg_error SHALL be 1 if N<2, N>MAX_PTS or log2_frames>MAX_LOG2_FR; while set, ready=0 and all samples are ignored.
REQ-021 A sample SHALL be accepted only when data_in_valid=1, enable=1 and ready=1; enable=0 holds state, point index and counters.
REQ-022 The point index SHALL increment per accepted sample and wrap from N-1 to 0; each wrap ends a frame.
REQ-023 The FSM SHALL have states IDLE, FIRST, ACCUM and LAST.
REQ-024 FSM transition IDLE->FIRST SHALL occur on the first cycle after reset release when cfg_error=0.
REQ-025 In FIRST, the accumulator SHALL be overwritten with the sample (mode 0) or with sample<<<L (mode 1).
REQ-026 Mode 0 transitions: FIRST->ACCUM at frame end (->LAST if M=2; if M=1, FIRST emits output itself and loops); ACCUM->LAST when frame_count=M-1; LAST->FIRST at frame end.
REQ-027 In ACCUM, acc[idx] SHALL be set to acc[idx]+sample.
REQ-028 In LAST, the block SHALL output (acc[idx]+sample)>>>L and SHALL NOT write the accumulator.
REQ-029 Mode 1 transition: FIRST->ACCUM at frame end; ACCUM SHALL never leave (LAST unused).
REQ-030 Mode 1 update: acc = acc + ((sample<<<L) - acc)>>>L, output = acc_new>>>L, on every frame including FIRST.
REQ-031 Accumulator width SHALL be DATA_W+MAX_LOG2_FR+1 signed per lane.
REQ-032 Shifts SHALL be arithmetic; output SHALL be truncated to DATA_W with no saturation needed, since the mean stays in range.
REQ-033 data_out_valid SHALL assert exactly 2 cycles after each accepted sample that produces output; between outputs data_out holds its last value.
REQ-034 The RAM read SHALL be issued in the accept cycle and the write SHALL occur 1 cycle later; N>=2 guarantees no read-after-write hazard.
REQ-035 frame_count SHALL increment at each frame end and return to 0 when a mode 0 block completes; in mode 1 it SHALL saturate at 16'hFFFF.
REQ-036 frame_done SHALL pulse in the same cycle as data_out_valid for point N-1 of an output frame.
REQ-037 Lanes SHALL be processed identically and independently, sharing index and FSM.

Reset
REQ-038 On reset_n=0: state=IDLE, index=0, frame_count=0, data_out=0, data_out_valid=0, frame_done=0, ready=0.
REQ-039 Accumulator RAM SHALL NOT be cleared; FIRST overwrites it.
REQ-040 Reset asserted mid-frame SHALL discard the pipeline; no output may be emitted from pre-reset samples after reset release.

Structure
REQ-041 Package frame_averager_pkg SHALL hold the state enum, mode constants (MODE_BLOCK=0, MODE_EMA=1) and the accumulator-width function.
REQ-042 Sub-module sdp_ram_acc SHALL be a simple dual-port RAM (1 read, 1 write, 1-cycle read latency), MAX_PTS x CHANNELS*ACC_W.

Verification
REQ-043 Mode 0, N=4, L=2, lane0 frames {1,2,3,4},{3,4,5,6},{5,6,7,8},{7,8,9,10} -> single output frame {4,5,6,7}, frame_done on the 4th output, then the next block restarts in FIRST.
REQ-044 Mode 0, N=2, L=1, lane1 = -3 and -4 on both frames -> outputs -3 and -4; arithmetic shift checked (-7>>>1 = -4 case included).
REQ-045 Mode 1, N=2, L=1, constant 10 then constant 20 -> outputs 10,10 then 15,15 then 17,17 (truncated).
REQ-046 ptos_x_ciclo=1 at reset -> cfg_error=1, ready=0, no data_out_valid for 100 valid samples.
REQ-047 enable toggled every other cycle with continuous valid -> results identical to the ungated run and latency still 2 cycles from each accepted sample.
REQ-048 reset pulsed mid-frame 2 of a mode 0 run -> no outputs from old data; a fresh block after release matches the expected averages.

Source files
------------

// File: rtl/frame_averager_pkg.sv
// Shared types and helpers for the multi-channel frame averager.
// Holds the FSM state encoding, averaging mode constants and accumulator sizing.
package frame_averager_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FIRST = 2'd1,
        ST_ACCUM = 2'd2,
        ST_LAST  = 2'd3
    } state_e;

    localparam logic MODE_BLOCK = 1'b0;
    localparam logic MODE_EMA   = 1'b1;

    // One guard bit on top of the worst-case sum of 2^max_log2_fr samples.
    function automatic int acc_width(input int data_w, input int max_log2_fr);
        return data_w + max_log2_fr + 1;
    endfunction

endpackage

// File: rtl/sdp_ram_acc.sv
// Simple dual-port accumulator RAM: one write port, one read port,
// read data registered (one cycle latency), contents never reset.
module sdp_ram_acc #(
    parameter int DEPTH  = 1024,
    parameter int WIDTH  = 82,
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] waddr_i,
    input  logic [WIDTH-1:0]  wdata_i,
    input  logic              re_i,
    input  logic [ADDR_W-1:0] raddr_i,
    output logic [WIDTH-1:0]  rdata_o
);

    logic [WIDTH-1:0] mem_q [0:DEPTH-1];
    logic [WIDTH-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
        if (re_i) begin
            rdata_q <= mem_q[raddr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/frame_averager_mc.sv
// Multi-channel frame averager: block average over 2^L frames or exponential
// average, per point of an N-point frame, with a two-stage RAM pipeline.
module frame_averager_mc
    import frame_averager_pkg::*;
#(
    parameter int CHANNELS    = 2,
    parameter int DATA_W      = 32,
    parameter int MAX_PTS     = 1024,
    parameter int MAX_LOG2_FR = 8
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       enable,
    input  logic [15:0]                ptos_x_ciclo,
    input  logic [3:0]                 log2_frames,
    input  logic                       mode,
    input  logic [CHANNELS*DATA_W-1:0] data_in,
    input  logic                       data_in_valid,
    output logic [CHANNELS*DATA_W-1:0] data_out,
    output logic                       data_out_valid,
    output logic                       ready,
    output logic                       cfg_error,
    output logic                       frame_done,
    output logic [15:0]                frame_count
);

    localparam int ACC_W  = acc_width(DATA_W, MAX_LOG2_FR);
    localparam int RAM_W  = CHANNELS * ACC_W;
    localparam int ADDR_W = (MAX_PTS > 1) ? $clog2(MAX_PTS) : 1;

    // Configuration tracks the inputs only while reset is held.
    logic [15:0] n_q;
    logic [3:0]  l_q;
    logic        mode_q;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            n_q    <= ptos_x_ciclo;
            l_q    <= log2_frames;
            mode_q <= mode;
        end
    end

    logic cfg_err;
    assign cfg_err = (n_q < 16'd2) || (int'(n_q) > MAX_PTS) || (int'(l_q) > MAX_LOG2_FR);

    state_e      state_q, state_d;
    logic [15:0] idx_q, idx_d;
    logic [15:0] fc_q, fc_d;

    logic        accept;
    logic        last_pt;
    logic        emit_s0;
    logic [15:0] m_minus1;

    assign accept   = data_in_valid && enable && (state_q != ST_IDLE);
    assign last_pt  = (idx_q == n_q - 16'd1);
    assign m_minus1 = (16'd1 << l_q) - 16'd1;
    assign emit_s0  = (mode_q == MODE_EMA) || (state_q == ST_LAST)
                   || ((state_q == ST_FIRST) && (l_q == 4'd0));

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            idx_q   <= 16'd0;
            fc_q    <= 16'd0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            fc_q    <= fc_d;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        fc_d    = fc_q;
        case (state_q)
            ST_IDLE: begin
                if (!cfg_err) begin
                    state_d = ST_FIRST;
                end
            end
            default: begin
                if (accept) begin
                    idx_d = last_pt ? 16'd0 : idx_q + 16'd1;
                    if (last_pt) begin
                        if (mode_q == MODE_EMA) begin
                            state_d = ST_ACCUM;
                            if (fc_q != 16'hFFFF) begin
                                fc_d = fc_q + 16'd1;
                            end
                        end else begin
                            case (state_q)
                                ST_FIRST: begin
                                    // M=1: every frame is a complete block on its own.
                                    if (l_q == 4'd0) begin
                                        fc_d = 16'd0;
                                    end else begin
                                        fc_d    = 16'd1;
                                        state_d = (m_minus1 == 16'd1) ? ST_LAST : ST_ACCUM;
                                    end
                                end
                                ST_ACCUM: begin
                                    fc_d = fc_q + 16'd1;
                                    if (fc_q + 16'd1 == m_minus1) begin
                                        state_d = ST_LAST;
                                    end
                                end
                                default: begin
                                    fc_d    = 16'd0;
                                    state_d = ST_FIRST;
                                end
                            endcase
                        end
                    end
                end
            end
        endcase
    end

    // Stage 1: sample and operation travel alongside the RAM read.
    logic                       s1_valid_q;
    logic                       s1_emit_q;
    logic                       s1_done_q;
    state_e                     s1_op_q;
    logic [ADDR_W-1:0]          s1_idx_q;
    logic [CHANNELS*DATA_W-1:0] s1_data_q;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            s1_valid_q <= 1'b0;
            s1_emit_q  <= 1'b0;
            s1_done_q  <= 1'b0;
        end else begin
            s1_valid_q <= accept;
            s1_emit_q  <= emit_s0;
            s1_done_q  <= emit_s0 && last_pt;
        end
        if (accept) begin
            s1_op_q   <= state_q;
            s1_idx_q  <= idx_q[ADDR_W-1:0];
            s1_data_q <= data_in;
        end
    end

    logic [RAM_W-1:0]           rd_data;
    logic [RAM_W-1:0]           wr_data;
    logic [CHANNELS*DATA_W-1:0] out_lane;
    logic                       ram_we;

    assign ram_we = s1_valid_q && !((mode_q == MODE_BLOCK) && (s1_op_q == ST_LAST));

    sdp_ram_acc #(
        .DEPTH  (MAX_PTS),
        .WIDTH  (RAM_W),
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk     (clk),
        .we_i    (ram_we),
        .waddr_i (s1_idx_q),
        .wdata_i (wr_data),
        .re_i    (accept),
        .raddr_i (idx_q[ADDR_W-1:0]),
        .rdata_o (rd_data)
    );

    genvar gi;
    generate
        for (gi = 0; gi < CHANNELS; gi++) begin : g_lane
            logic signed [ACC_W-1:0] sample_x;
            logic signed [ACC_W-1:0] acc_rd;
            logic signed [ACC_W-1:0] acc_new;
            logic signed [ACC_W:0]   ema_diff;

            assign sample_x = ACC_W'($signed(s1_data_q[gi*DATA_W +: DATA_W]));
            assign acc_rd   = $signed(rd_data[gi*ACC_W +: ACC_W]);

            always_comb begin
                acc_new  = acc_rd + sample_x;
                ema_diff = '0;
                if (mode_q == MODE_EMA) begin
                    if (s1_op_q == ST_FIRST) begin
                        acc_new = sample_x <<< l_q;
                    end else begin
                        // One extra bit so the difference cannot wrap before the shift.
                        ema_diff = ((ACC_W+1)'(sample_x <<< l_q) - (ACC_W+1)'(acc_rd)) >>> l_q;
                        acc_new  = acc_rd + ACC_W'(ema_diff);
                    end
                end else if (s1_op_q == ST_FIRST) begin
                    acc_new = sample_x;
                end
            end

            assign wr_data[gi*ACC_W +: ACC_W]   = acc_new;
            assign out_lane[gi*DATA_W +: DATA_W] = DATA_W'(acc_new >>> l_q);
        end
    endgenerate

    logic [CHANNELS*DATA_W-1:0] data_out_q;
    logic                       data_out_valid_q;
    logic                       frame_done_q;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            data_out_q       <= '0;
            data_out_valid_q <= 1'b0;
            frame_done_q     <= 1'b0;
        end else begin
            data_out_valid_q <= s1_valid_q && s1_emit_q;
            frame_done_q     <= s1_valid_q && s1_done_q;
            if (s1_valid_q && s1_emit_q) begin
                data_out_q <= out_lane;
            end
        end
    end

    assign data_out       = data_out_q;
    assign data_out_valid = data_out_valid_q;
    assign frame_done     = frame_done_q;
    assign frame_count    = fc_q;
    assign ready          = (state_q != ST_IDLE);
    assign cfg_error      = cfg_err;

endmodule
